// File: rtl/spi_lcd_rx.sv
// spi_lcd_rx: receive side of the 4-wire SPI display link (SCLK/MOSI/DC/CS).
// Latency: 4 i_clk cycles from the 8th SCLK rise of a byte to o_cmd_valid / o_pix_valid.
// Backpressure: none. The link cannot be stalled, so every byte is consumed as it arrives.
//
// Oversamples the link in the i_clk domain and deframes bytes. It decodes the
// column-address, page-address and memory-write commands, tracks the address
// window, and emits one addressed RGB888 pixel for every 3 data bytes.
//
// Ports:
//   i_clk, i_rst                  system clock (>= 4x SCLK), async active-high reset
//   i_sclk, i_mosi, i_dc, i_cs    raw SPI mode-0 link, MSB first, CS active-low
//   o_cmd_valid, o_cmd            pulse per command byte; last command is held
//   o_pix_valid, o_pix_x/y/data   pulse per completed pixel with its coordinates
//   o_err                         pulse when CS rises with a partial byte pending
//   o_pix_count                   pixels since the last memory-write command
//
// Optional feature: define SPI_RX_PIXCNT_EN to build the saturating pixel
// counter. When the macro is undefined, o_pix_count is tied to 0.

module spi_lcd_rx #(
    parameter int          COORD_W    = 16,
    parameter logic [7:0]  SET_COLUMN = 8'h2A,
    parameter logic [7:0]  SET_PAGE   = 8'h2B,
    parameter logic [7:0]  WRITE_RAM  = 8'h2C
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_sclk,
    input  logic               i_mosi,
    input  logic               i_dc,
    input  logic               i_cs,
    output logic               o_cmd_valid,
    output logic [7:0]         o_cmd,
    output logic               o_pix_valid,
    output logic [COORD_W-1:0] o_pix_x,
    output logic [COORD_W-1:0] o_pix_y,
    output logic [23:0]        o_pix_data,
    output logic               o_err,
    output logic [31:0]        o_pix_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CASET = 2'd1,
        S_PASET = 2'd2,
        S_RAMWR = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronisers
    // ------------------------------------------------------------------
    logic r_sclk_s1, r_sclk_s2, r_sclk_d;
    logic r_mosi_s1, r_mosi_s2;
    logic r_dc_s1,   r_dc_s2;
    logic r_cs_s1,   r_cs_s2;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sclk_s1 <= 1'b0;
            r_sclk_s2 <= 1'b0;
            r_sclk_d  <= 1'b0;
            r_mosi_s1 <= 1'b0;
            r_mosi_s2 <= 1'b0;
            r_dc_s1   <= 1'b0;
            r_dc_s2   <= 1'b0;
            r_cs_s1   <= 1'b0;
            r_cs_s2   <= 1'b0;
        end else begin
            r_sclk_s1 <= i_sclk;
            r_sclk_s2 <= r_sclk_s1;
            r_sclk_d  <= r_sclk_s2;
            r_mosi_s1 <= i_mosi;
            r_mosi_s2 <= r_mosi_s1;
            r_dc_s1   <= i_dc;
            r_dc_s2   <= r_dc_s1;
            r_cs_s1   <= i_cs;
            r_cs_s2   <= r_cs_s1;
        end
    end

    logic w_sclk_rise;
    assign w_sclk_rise = r_sclk_s2 & ~r_sclk_d;

    // ------------------------------------------------------------------
    // Deframer. A deselected link (sync'd CS high) takes priority over a
    // coincident SCLK rise, so that bit is dropped. r_shift holds the
    // completed byte while r_byte_vld is high. It stays stable because the
    // next SCLK rise is at least 4 cycles away.
    // ------------------------------------------------------------------
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic       r_byte_vld;
    logic       r_byte_dc;
    logic       r_err;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'd0;
            r_byte_vld <= 1'b0;
            r_byte_dc  <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_byte_vld <= 1'b0;
            r_err      <= 1'b0;
            if (r_cs_s2) begin
                r_bit_cnt <= 3'd0;
                r_shift   <= 8'd0;
                r_err     <= (r_bit_cnt != 3'd0);
            end else if (w_sclk_rise) begin
                r_shift   <= {r_shift[6:0], r_mosi_s2};
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    r_byte_vld <= 1'b1;
                    r_byte_dc  <= r_dc_s2;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Command / data FSM with registered outputs
    // ------------------------------------------------------------------
    state_t             r_state;
    logic [2:0]         r_pidx;        // parameter byte index, saturates at 4
    logic [7:0]         r_p0, r_p1, r_p2;
    logic [COORD_W-1:0] r_xs, r_xe, r_ys, r_ye;
    logic [COORD_W-1:0] r_x, r_y;
    logic [1:0]         r_bidx;        // pixel byte index 0..2
    logic [7:0]         r_b0, r_b1;
    logic               r_cmd_valid;
    logic [7:0]         r_cmd;
    logic               r_pix_valid;
    logic [COORD_W-1:0] r_pix_x, r_pix_y;
    logic [23:0]        r_pix_data;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_pidx      <= 3'd0;
            r_p0        <= 8'd0;
            r_p1        <= 8'd0;
            r_p2        <= 8'd0;
            r_xs        <= '0;
            r_xe        <= '0;
            r_ys        <= '0;
            r_ye        <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_bidx      <= 2'd0;
            r_b0        <= 8'd0;
            r_b1        <= 8'd0;
            r_cmd_valid <= 1'b0;
            r_cmd       <= 8'd0;
            r_pix_valid <= 1'b0;
            r_pix_x     <= '0;
            r_pix_y     <= '0;
            r_pix_data  <= 24'd0;
        end else begin
            r_cmd_valid <= 1'b0;
            r_pix_valid <= 1'b0;
            if (r_byte_vld) begin
                if (!r_byte_dc) begin
                    r_cmd_valid <= 1'b1;
                    r_cmd       <= r_shift;
                    r_pidx      <= 3'd0;
                    if (r_shift == SET_COLUMN) begin
                        r_state <= S_CASET;
                    end else if (r_shift == SET_PAGE) begin
                        r_state <= S_PASET;
                    end else if (r_shift == WRITE_RAM) begin
                        r_state <= S_RAMWR;
                        r_x     <= r_xs;
                        r_y     <= r_ys;
                        r_bidx  <= 2'd0;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end else begin
                    case (r_state)
                        S_CASET, S_PASET: begin
                            // Start/end commit together on the 4th byte, so a
                            // truncated sequence leaves the window untouched.
                            if (r_pidx != 3'd4) begin
                                r_pidx <= r_pidx + 3'd1;
                                case (r_pidx[1:0])
                                    2'd0: r_p0 <= r_shift;
                                    2'd1: r_p1 <= r_shift;
                                    2'd2: r_p2 <= r_shift;
                                    default: begin
                                        if (r_state == S_CASET) begin
                                            r_xs <= COORD_W'({r_p0, r_p1});
                                            r_xe <= COORD_W'({r_p2, r_shift});
                                        end else begin
                                            r_ys <= COORD_W'({r_p0, r_p1});
                                            r_ye <= COORD_W'({r_p2, r_shift});
                                        end
                                    end
                                endcase
                            end
                        end
                        S_RAMWR: begin
                            case (r_bidx)
                                2'd0: begin
                                    r_b0   <= r_shift;
                                    r_bidx <= 2'd1;
                                end
                                2'd1: begin
                                    r_b1   <= r_shift;
                                    r_bidx <= 2'd2;
                                end
                                default: begin
                                    r_bidx      <= 2'd0;
                                    r_pix_valid <= 1'b1;
                                    r_pix_x     <= r_x;
                                    r_pix_y     <= r_y;
                                    r_pix_data  <= {r_b0, r_b1, r_shift};
                                    // Using >= (not ==) makes an inverted
                                    // window collapse to a single column/row.
                                    if (r_x >= r_xe) begin
                                        r_x <= r_xs;
                                        r_y <= (r_y >= r_ye) ? r_ys : r_y + COORD_W'(1);
                                    end else begin
                                        r_x <= r_x + COORD_W'(1);
                                    end
                                end
                            endcase
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign o_cmd_valid = r_cmd_valid;
    assign o_cmd       = r_cmd;
    assign o_pix_valid = r_pix_valid;
    assign o_pix_x     = r_pix_x;
    assign o_pix_y     = r_pix_y;
    assign o_pix_data  = r_pix_data;
    assign o_err       = r_err;

`ifdef SPI_RX_PIXCNT_EN
    // Counts pixel pulses since the last memory-write command and saturates
    // at the maximum value.
    logic [31:0] r_pix_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pix_cnt <= 32'd0;
        end else if (r_byte_vld && !r_byte_dc && (r_shift == WRITE_RAM)) begin
            r_pix_cnt <= 32'd0;
        end else if (r_pix_valid && (r_pix_cnt != 32'hFFFF_FFFF)) begin
            r_pix_cnt <= r_pix_cnt + 32'd1;
        end
    end

    assign o_pix_count = r_pix_cnt;
`else
    assign o_pix_count = 32'd0;
`endif

endmodule
